// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared definitions for the 5-stage MIPS pipeline control.
//               Holds the front-end freeze FSM state type, default address
//               and register-specifier widths, and the zero-register index.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // Front-end freeze FSM: RUN = normal flow, WAIT = frozen on memory busy.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int REG_W_DEFAULT  = 5;

    // $zero is hard-wired, so a load targeting it never creates a hazard.
    localparam int unsigned REG_ZERO = 0;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter used for bring-up statistics. Stops at
//               all-ones and never wraps.
// Ports       : clk   - clock
//               reset - synchronous active-high reset, clears the count
//               inc   - count enable for this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hazard_ctrl
// Description : Front-end pipeline control for the 5-stage MIPS core. Decides
//               each cycle whether the PC advances, holds or is redirected.
//               Detects load-use hazards, freezes on memory busy, remembers a
//               branch/jump redirect that arrives while frozen, and keeps
//               saturating stall / redirect statistics counters.
// Config      : HAZARD_DELAY_SLOT_EN - when defined, redirects keep the
//               already-fetched instruction (branch delay slot); otherwise
//               the wrong-path instruction in IF/ID is flushed.
// Ports       : clk, reset (sync, active-high)
//               id_rs, id_rt, id_uses_rt       - ID-stage operand specifiers
//               ex_mem_read, ex_rt             - load in EX and its target
//               mem_busy                       - memory not ready, freeze
//               branch_taken/branch_address    - ID branch resolution
//               jump/jump_address              - ID jump
//               pc_write, redirect_valid, redirect_address
//               if_id_write, if_id_flush, id_ex_flush
//               stall_cnt, redirect_cnt        - statistics (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              mem_busy,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_address,
    output logic              pc_write,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_address,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

`ifdef HAZARD_DELAY_SLOT_EN
    localparam logic c_FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam logic c_FLUSH_ON_REDIRECT = 1'b1;
`endif

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;

    logic              w_load_use;
    logic              w_live;
    logic [ADDR_W-1:0] w_live_addr;
    logic              w_apply;

    assign w_load_use = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Jump wins over a taken branch when both resolve in the same cycle.
    assign w_live      = jump | branch_taken;
    assign w_live_addr = jump ? jump_address : branch_address;

    // Output decision, priority reset > busy > load-use > redirect > normal.
    always_comb begin
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        redirect_valid   = 1'b0;
        redirect_address = '0;
        w_apply          = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (w_load_use) begin
            // Branch operands are stale here; ID re-resolves next cycle.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (w_live || r_pend_valid) begin
            // A freshly resolved redirect supersedes the remembered one.
            redirect_valid   = 1'b1;
            redirect_address = w_live ? w_live_addr : r_pend_addr;
            if_id_flush      = c_FLUSH_ON_REDIRECT;
            w_apply          = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     w_state_next = mem_busy ? WAIT : RUN;
            WAIT:    w_state_next = mem_busy ? WAIT : RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pending redirect: captured while frozen (latest wins), consumed once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
        end else if (mem_busy && w_live) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_live_addr;
        end else if (w_apply) begin
            r_pend_valid <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!reset && !pc_write),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_apply),
        .count (redirect_cnt)
    );

endmodule : fetch_hazard_ctrl
`default_nettype wire

// File: tb/tb_fetch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_hazard_ctrl
// Description : Self-checking bench for fetch_hazard_ctrl. Directed scenarios
//               followed by random traffic, compared against a cycle-level
//               behavioural model of the control rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_hazard_ctrl;

    localparam int ADDR_W = 10;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_W-1:0]  id_rs, id_rt, ex_rt;
    logic              id_uses_rt, ex_mem_read, mem_busy;
    logic              branch_taken, jump;
    logic [ADDR_W-1:0] branch_address, jump_address;
    logic              pc_write, redirect_valid, if_id_write, if_id_flush, id_ex_flush;
    logic [ADDR_W-1:0] redirect_address;
    logic [CNT_W-1:0]  stall_cnt, redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_pend;
    int m_pend_addr;
    int m_stall;
    int m_redir;
    bit m_cnt_known = 0;

`ifdef HAZARD_DELAY_SLOT_EN
    localparam bit REDIR_FLUSH = 1'b0;
`else
    localparam bit REDIR_FLUSH = 1'b1;
`endif

    always #5 clk = ~clk;

    fetch_hazard_ctrl #(
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .ex_mem_read      (ex_mem_read),
        .ex_rt            (ex_rt),
        .mem_busy         (mem_busy),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .jump             (jump),
        .jump_address     (jump_address),
        .pc_write         (pc_write),
        .redirect_valid   (redirect_valid),
        .redirect_address (redirect_address),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .stall_cnt        (stall_cnt),
        .redirect_cnt     (redirect_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        mem_busy = 0; branch_taken = 0; branch_address = 0; jump = 0; jump_address = 0;
    endtask

    // One cycle: inputs are already driven; check at negedge, advance model
    // and the DUT at the following posedge.
    task automatic step();
        bit hazard, live, e_pcw, e_ifw, e_iff, e_idf, e_rv;
        int live_addr, e_ra;
        @(negedge clk);
        hazard    = ex_mem_read && (ex_rt != 0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        live      = jump || branch_taken;
        live_addr = jump ? int'(jump_address) : int'(branch_address);
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_rv = 0; e_ra = 0;
        if (reset) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (mem_busy) begin
            e_pcw = 0; e_ifw = 0;
        end else if (hazard) begin
            e_pcw = 0; e_ifw = 0; e_idf = 1;
        end else if (live || m_pend) begin
            e_rv = 1; e_iff = REDIR_FLUSH;
            e_ra = live ? live_addr : m_pend_addr;
        end
        chk("pc_write", int'(pc_write), int'(e_pcw));
        chk("if_id_write", int'(if_id_write), int'(e_ifw));
        chk("if_id_flush", int'(if_id_flush), int'(e_iff));
        chk("id_ex_flush", int'(id_ex_flush), int'(e_idf));
        chk("redirect_valid", int'(redirect_valid), int'(e_rv));
        chk("redirect_address", int'(redirect_address), e_ra);
        if (m_cnt_known) begin
            chk("stall_cnt", int'(stall_cnt), m_stall);
            chk("redirect_cnt", int'(redirect_cnt), m_redir);
        end
        // Model update for the coming edge.
        if (reset) begin
            m_pend = 0; m_pend_addr = 0; m_stall = 0; m_redir = 0; m_cnt_known = 1;
        end else begin
            if (!e_pcw && m_stall < CNT_MAX) m_stall++;
            if (mem_busy) begin
                if (live) begin m_pend = 1; m_pend_addr = live_addr; end
            end else if (e_rv) begin
                m_pend = 0;
                if (m_redir < CNT_MAX) m_redir++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step();
        step();
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_redirect_cnt", int'(redirect_cnt), 0);
        reset = 0;

        // Load-use on rs: one stall cycle, then clear.
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        step();
        idle_inputs();
        step();
        chk("loaduse_stall_cnt", int'(stall_cnt), 1);

        // Load into $zero never stalls.
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        step();
        idle_inputs();

        // Jump beats taken branch.
        jump = 1; jump_address = 10'h040; branch_taken = 1; branch_address = 10'h080;
        step();
        idle_inputs();
        step();

        // Freeze 3 cycles with a branch pulse in the first one.
        reset = 1; step(); reset = 0;
        mem_busy = 1; branch_taken = 1; branch_address = 10'h100;
        step();
        branch_taken = 0; branch_address = 0;
        step();
        step();
        mem_busy = 0;
        step();
        chk("resume_counts_redirect", int'(redirect_cnt), 1);
        chk("resume_counts_stall", int'(stall_cnt), 3);
        step();

        // Load-use masks a same-cycle branch; applied next cycle.
        ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1;
        branch_taken = 1; branch_address = 10'h2A4;
        step();
        ex_mem_read = 0;
        step();
        idle_inputs();
        step();

        // Saturation, then reset while frozen with pending set.
        mem_busy = 1; jump = 1; jump_address = 10'h3C0;
        for (int i = 0; i < 20; i++) begin
            step();
            jump = 0;
        end
        chk("stall_saturated", int'(stall_cnt), CNT_MAX);
        reset = 1;
        step();
        idle_inputs();
        step();
        chk("post_reset_no_redirect", int'(redirect_valid), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            mem_busy       = ($urandom_range(0, 3) == 0);
            ex_mem_read    = $urandom_range(0, 1);
            ex_rt          = REG_W'($urandom_range(0, 3));
            id_rs          = REG_W'($urandom_range(0, 3));
            id_rt          = REG_W'($urandom_range(0, 3));
            id_uses_rt     = $urandom_range(0, 1);
            branch_taken   = ($urandom_range(0, 4) == 0);
            jump           = ($urandom_range(0, 9) == 0);
            branch_address = ADDR_W'($urandom);
            jump_address   = ADDR_W'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_hazard_ctrl
`default_nettype wire
